pipelined_cla_adder: RTL and testbench
======================================

Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready handshake on both sides.
- Operands are split into BLOCK-bit lookahead groups. Each pipeline stage resolves one group; the group carry is registered into the next stage.
- Successor to the fixed 4-bit combinational CLA. Used wherever the datapath needs wide add/sub at full clock rate with backpressure.

Parameters:
- WIDTH, 16, operand and result width; must be a multiple of BLOCK.
- BLOCK, 4, bits per lookahead group; pipeline depth NSTG = WIDTH/BLOCK.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A, two's complement or unsigned.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in in add mode; borrow-in in sub mode.
- sub  in  1  0 = A+B+cin; 1 = A-B-cin.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  add: carry-out; sub: NOT borrow-out (1 = no borrow).
- ovf  out  1  signed overflow.
- zero  out  1  sum == 0.

Behaviour:
- Reset (async, rst_n low):
  - all stage valid bits clear;
  - out_valid=0, sum=0, cout=0, ovf=0, zero=0;
  - in_ready=1 once rst_n is high.
  - Reset mid-operation discards all in-flight beats; no partial result is ever presented.
- Operand conditioning at input:
  - b_eff = sub ? ~b : b;
  - c0 = sub ? ~cin : cin.
- Per group k (bits k*BLOCK .. k*BLOCK+BLOCK-1):
  - g = a&b_eff, p = a^b_eff;
  - internal carries by lookahead, not ripple, from the carry entering the group;
  - group sum bits = p ^ carries.
- Stage k computes group k using the carry registered from stage k-1 (c0 for stage 0).
  - Higher operand groups are carried along in skew registers until their stage.
  - Lower sum groups are carried along in deskew registers until the output.
- Global advance enable: adv = out_ready | ~out_valid.
  - in_ready = adv.
  - All stage registers (data and valid) update only when adv=1.
  - A beat is accepted iff in_valid & in_ready.
  - Empty slots propagate as bubbles; bubbles are not collapsed.
- Latency: NSTG cycles from accept to out_valid when out_ready stays high. Throughput: one beat per cycle.
- Backpressure (out_valid=1, out_ready=0):
  - whole pipe freezes; in_ready=0;
  - sum, cout, ovf, zero held stable until the handshake completes.
- Outputs are registered:
  - cout = carry out of the MSB group;
  - ovf = carry into MSB XOR carry out of MSB;
  - zero = ~|sum.
- Wrap-around: results are modulo 2^WIDTH; cout and ovf report the out-of-range condition.
- Simultaneous in/out handshake in the same cycle is legal; no beat is lost or duplicated.
- Ordering: results leave in acceptance order.
- Elaboration: WIDTH % BLOCK != 0 or BLOCK < 1 is a fatal elaboration error.

Decomposition:
- Shared package cla_pkg:
  - default WIDTH/BLOCK constants;
  - a function returning NSTG;
  - the flag-bundle typedef {cout, ovf, zero}.
- Sub-module cla_group:
  - combinational BLOCK-bit lookahead group;
  - inputs a, b, c_in; outputs s, c_out, c_msb_in (carry into the group MSB, used for ovf).
  - Instantiated NSTG times, one per stage.

Test Plan (WIDTH=16, BLOCK=4, out_ready=1 unless stated):
- a=0x0003, b=0x0007, cin=0, sub=0 -> 4 cycles later: sum=0x000A, cout=0, ovf=0, zero=0.
- a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0, zero=1. This checks carry propagation across all four stages.
- a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1, cout=0. Then a=0x8000, b=0x0001, sub=1, cin=0 -> sum=0x7FFF, ovf=1, cout=1.
- a=0x0005, b=0x0003, sub=1, cin=1 -> sum=0x0001, cout=1. Then a=0x0000, b=0x0001, sub=1, cin=0 -> sum=0xFFFF, cout=0 (borrow).
- Stream 8 back-to-back beats (a=i, b=i, i=0..7); drop out_ready for cycles 6-8 -> in_ready=0 in those cycles, output held stable. Expect exactly 8 results 0,2,..,14 in order, none duplicated.
- Accept 3 beats, assert rst_n=0 for 1 cycle mid-flight -> out_valid stays 0 and no stale result appears. A new beat afterwards returns its correct sum after 4 cycles.

Source files
------------

// File: rtl/cla_pkg.sv
// cla_pkg: shared constants, pipeline-depth helper and result-flag bundle
// for the pipelined carry-lookahead adder/subtractor.
//   CLA_WIDTH / CLA_BLOCK : default operand width and lookahead group size
//   cla_nstg()            : number of pipeline stages (one per group)
//   cla_flags_t           : {cout, ovf, zero} status bundle
package cla_pkg;

    localparam int unsigned CLA_WIDTH = 32'd16;
    localparam int unsigned CLA_BLOCK = 32'd4;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } cla_flags_t;

    // Pipeline depth; a zero group size yields zero stages and is rejected
    // by the elaboration check in the top level.
    function automatic int unsigned cla_nstg(input int unsigned width,
                                             input int unsigned block);
        if (block == 32'd0) begin
            return 32'd0;
        end else begin
            return width / block;
        end
    endfunction

endpackage : cla_pkg

// File: rtl/cla_group.sv
// cla_group: combinational BLOCK-bit carry-lookahead group.
//   a, b      : group operand bits (b already conditioned for subtraction)
//   c_in      : carry entering the group
//   s         : group sum bits
//   c_out     : carry leaving the group MSB
//   c_msb_in  : carry entering the group MSB (for signed overflow)
module cla_group #(
    parameter int unsigned BLOCK = 32'd4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             c_in,
    output logic [BLOCK-1:0] s,
    output logic             c_out,
    output logic             c_msb_in
);

    logic [BLOCK-1:0] g_s;
    logic [BLOCK-1:0] p_s;
    logic [BLOCK:0]   c_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

    // Lookahead carries: every c[i] is an OR of generate terms, each ANDed
    // with the propagates above it, plus the fully propagated c_in term.
    // No carry depends on another computed carry.
    always_comb begin
        c_s = {(BLOCK + 1){1'b0}};
        for (int i = 0; i <= int'(BLOCK); i++) begin
            logic acc;
            logic prop;
            acc  = 1'b0;
            prop = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                acc  = acc | (g_s[j] & prop);
                prop = prop & p_s[j];
            end
            c_s[i] = acc | (prop & c_in);
        end
    end

    assign s        = p_s ^ c_s[BLOCK-1:0];
    assign c_out    = c_s[BLOCK];
    assign c_msb_in = c_s[BLOCK-1];

endmodule : cla_group

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: WIDTH-bit add/subtract, one BLOCK-bit lookahead group
// resolved per pipeline stage, valid/ready handshake on both sides.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand beat handshake (a, b, cin, sub)
//   out_valid/out_ready : result beat handshake (sum, cout, ovf, zero)
//   sub=1 computes a-b-cin; cout is then NOT borrow-out.
// Latency is NSTG cycles; the whole pipe freezes while a result is stalled.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = CLA_WIDTH,
    parameter int unsigned BLOCK = CLA_BLOCK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NSTG = cla_nstg(WIDTH, BLOCK);

    if (BLOCK < 32'd1) begin : g_chk_block
        $fatal(1, "pipelined_cla_adder: BLOCK must be at least 1");
    end else if ((WIDTH % BLOCK) != 32'd0) begin : g_chk_width
        $fatal(1, "pipelined_cla_adder: WIDTH must be a multiple of BLOCK");
    end

    // Single advance enable: the pipe moves only when the output slot is
    // empty or being drained this cycle.
    logic adv_s;
    assign adv_s    = out_ready | ~out_valid;
    assign in_ready = adv_s;

    for (genvar k = 0; k < int'(NSTG); k++) begin : g_stg
        localparam int unsigned LO = k * BLOCK;    // first bit of group k
        localparam int unsigned HW = WIDTH - LO;   // operand bits still pending

        logic [HW-1:0]       a_in_s;
        logic [HW-1:0]       b_in_s;
        logic [LO+BLOCK-1:0] s_nxt_s;
        logic                c_in_s;
        logic                v_in_s;
        logic [BLOCK-1:0]    gs_s;
        logic                gc_s;
        logic                gm_s;
        logic                v_q;

        if (k == 0) begin : g_src
            // Subtraction as a + ~b + ~cin.
            assign a_in_s  = a;
            assign b_in_s  = sub ? ~b : b;
            assign c_in_s  = sub ? ~cin : cin;
            assign v_in_s  = in_valid;
            assign s_nxt_s = gs_s;
        end else begin : g_src
            assign a_in_s  = g_stg[k-1].g_mid.a_q;
            assign b_in_s  = g_stg[k-1].g_mid.b_q;
            assign c_in_s  = g_stg[k-1].g_mid.c_q;
            assign v_in_s  = g_stg[k-1].v_q;
            assign s_nxt_s = {gs_s, g_stg[k-1].g_mid.s_q};
        end

        cla_group #(.BLOCK(BLOCK)) u_grp (
            .a        (a_in_s[BLOCK-1:0]),
            .b        (b_in_s[BLOCK-1:0]),
            .c_in     (c_in_s),
            .s        (gs_s),
            .c_out    (gc_s),
            .c_msb_in (gm_s)
        );

        // Stage valid bit; empty slots travel as bubbles.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
            end else if (adv_s) begin
                v_q <= v_in_s;
            end
        end

        if (k < int'(NSTG) - 1) begin : g_mid
            logic [HW-BLOCK-1:0] a_q;   // skew: groups not yet resolved
            logic [HW-BLOCK-1:0] b_q;
            logic [LO+BLOCK-1:0] s_q;   // deskew: groups already resolved
            logic                c_q;   // carry into the next group

            // Intermediate stage data registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= {(HW - BLOCK){1'b0}};
                    b_q <= {(HW - BLOCK){1'b0}};
                    s_q <= {(LO + BLOCK){1'b0}};
                    c_q <= 1'b0;
                end else if (adv_s) begin
                    a_q <= a_in_s[HW-1:BLOCK];
                    b_q <= b_in_s[HW-1:BLOCK];
                    s_q <= s_nxt_s;
                    c_q <= gc_s;
                end
            end
        end else begin : g_last
            cla_flags_t     flags_d;
            cla_flags_t     flags_q;
            logic [WIDTH-1:0] s_q;

            // Result flags from the MSB group.
            always_comb begin
                flags_d.cout = gc_s;
                flags_d.ovf  = gm_s ^ gc_s;
                flags_d.zero = ~|s_nxt_s;
            end

            // Output registers; held while the consumer stalls.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s_q     <= {WIDTH{1'b0}};
                    flags_q <= '{cout: 1'b0, ovf: 1'b0, zero: 1'b0};
                end else if (adv_s) begin
                    s_q     <= s_nxt_s;
                    flags_q <= flags_d;
                end
            end
        end
    end

    assign out_valid = g_stg[NSTG-1].v_q;
    assign sum       = g_stg[NSTG-1].g_last.s_q;
    assign cout      = g_stg[NSTG-1].g_last.flags_q.cout;
    assign ovf       = g_stg[NSTG-1].g_last.flags_q.ovf;
    assign zero      = g_stg[NSTG-1].g_last.flags_q.zero;

endmodule : pipelined_cla_adder

// File: tb/tb_pipelined_cla_adder.sv
// Directed self-checking bench for pipelined_cla_adder (WIDTH=16, BLOCK=4).
module tb_pipelined_cla_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;

    int n_vec;
    int n_err;

    pipelined_cla_adder #(.WIDTH(32'd16), .BLOCK(32'd4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one beat, wait for its result (bounded) and check everything.
    task automatic run_vec(input string tag, input logic [15:0] va,
                           input logic [15:0] vb, input logic vcin,
                           input logic vsub, input logic [15:0] es,
                           input logic ec, input logic eo, input logic ez);
        int lat;
        a        = va;
        b        = vb;
        cin      = vcin;
        sub      = vsub;
        in_valid = 1'b1;
        #1;
        check_eq({tag, "/in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            tick();
            lat++;
        end
        check_eq({tag, "/latency"}, 32'(lat), 32'd4);
        check_eq({tag, "/sum"}, 32'(sum), 32'(es));
        check_eq({tag, "/cout"}, 32'(cout), 32'(ec));
        check_eq({tag, "/ovf"}, 32'(ovf), 32'(eo));
        check_eq({tag, "/zero"}, 32'(zero), 32'(ez));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int rx;
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = 16'h0000;
        b         = 16'h0000;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;

        #2;
        check_eq("reset/out_valid", 32'(out_valid), 32'd0);
        check_eq("reset/sum", 32'(sum), 32'd0);
        check_eq("reset/cout", 32'(cout), 32'd0);
        check_eq("reset/ovf", 32'(ovf), 32'd0);
        check_eq("reset/zero", 32'(zero), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("reset/in_ready", 32'(in_ready), 32'd1);

        run_vec("add_small", 16'h0003, 16'h0007, 1'b0, 1'b0, 16'h000A, 1'b0, 1'b0, 1'b0);
        run_vec("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_vec("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_vec("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        run_vec("sub_bin",   16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
        run_vec("sub_borrow", 16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        run_vec("add_cin",   16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);

        // Back-to-back stream with a three-cycle consumer stall.
        sent = 0;
        rx   = 0;
        for (int c = 0; c < 24; c++) begin
            out_ready = !(c >= 6 && c <= 8);
            in_valid  = (sent < 8);
            a         = 16'(sent);
            b         = 16'(sent);
            cin       = 1'b0;
            sub       = 1'b0;
            #1;
            if (c >= 6 && c <= 8) begin
                check_eq("stream/stall_in_ready", 32'(in_ready), 32'd0);
                check_eq("stream/stall_valid", 32'(out_valid), 32'd1);
                check_eq("stream/stall_hold", 32'(sum), 32'(2 * rx));
            end
            if (out_valid && out_ready) begin
                check_eq("stream/result", 32'(sum), 32'(2 * rx));
                rx++;
            end
            if (in_valid && in_ready) begin
                sent++;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_eq("stream/accepted", 32'(sent), 32'd8);
        check_eq("stream/results", 32'(rx), 32'd8);

        // Reset with three beats in flight: nothing may emerge afterwards.
        for (int i = 0; i < 3; i++) begin
            a        = 16'(16'h0010 + i);
            b        = 16'h0001;
            cin      = 1'b0;
            sub      = 1'b0;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_eq("midrst/out_valid_in_reset", 32'(out_valid), 32'd0);
        check_eq("midrst/sum_in_reset", 32'(sum), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check_eq("midrst/no_stale", 32'(out_valid), 32'd0);
            tick();
        end
        run_vec("midrst/new", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pipelined_cla_adder
